// File: rtl/tpu_operand_feeder.sv
// Operand feeder: queues sign-magnitude operand pairs and streams vec_len of them to a MAC stage.
// Outputs are registered one edge after the state that produces them; in_ready depends only on FIFO occupancy.
module tpu_operand_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] vec_len,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] input1,
  output logic [7:0] input2,
  output logic       mac_clear,
  output logic       dot_done,
  output logic       busy,
  output logic       error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             fifo_empty, push, pop;
  logic [15:0]      head;
  logic [3:0]       len_q, len_nxt, pair_cnt, cnt_nxt;
  logic [7:0]       op1_nxt, op2_nxt;
  logic             clear_nxt, done_nxt, error_nxt;

  // Negative zero would look like a live operand to the MAC; fold it to +0.
  function automatic logic [7:0] canon(input logic [7:0] v);
    return (v == 8'h80) ? 8'h00 : v;
  endfunction

  assign fifo_empty = (occ == '0);
  assign in_ready   = (occ != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    cnt_nxt   = pair_cnt;
    pop       = 1'b0;
    op1_nxt   = 8'h00;
    op2_nxt   = 8'h00;
    clear_nxt = 1'b0;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    if (start && (state != IDLE)) begin
      error_nxt = 1'b1;
    end
    case (state)
      IDLE: begin
        if (start) begin
          if (vec_len == 4'd0) begin
            error_nxt = 1'b1;
          end else begin
            len_nxt   = vec_len;
            cnt_nxt   = 4'd0;
            state_nxt = CLEAR;
          end
        end
      end
      CLEAR: begin
        clear_nxt = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // An empty FIFO leaves a zero bubble and the count untouched.
        if (!fifo_empty) begin
          pop     = 1'b1;
          op1_nxt = canon(head[15:8]);
          op2_nxt = canon(head[7:0]);
          cnt_nxt = pair_cnt + 4'd1;
          if (cnt_nxt == len_q) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= 4'd0;
      pair_cnt  <= 4'd0;
      input1    <= 8'h00;
      input2    <= 8'h00;
      mac_clear <= 1'b0;
      dot_done  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      pair_cnt  <= cnt_nxt;
      input1    <= op1_nxt;
      input2    <= op2_nxt;
      mac_clear <= clear_nxt;
      dot_done  <= done_nxt;
      error     <= error_nxt;
    end
  end

endmodule

// File: doc/tpu_operand_feeder.md
TPU_OPERAND_FEEDER -- requirements
Module: tpu_operand_feeder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered operand pairs (power of two, >=2).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin one dot product; accepted only in IDLE.
REQ-005 vec_len  input  4  pairs per dot product (1..15), sampled when start is accepted.
REQ-006 in_valid  input  1  upstream pair valid.
REQ-007 in_ready  output  1  feeder can accept a pair; equals FIFO not full.
REQ-008 in_a, in_b  input  8 each  operands, sign-magnitude (bit7 sign, bits6:0 magnitude).
REQ-009 input1, input2  output  8 each  registered operands to the MAC stage, sign-magnitude.
REQ-010 mac_clear  output  1  one-cycle pulse clearing the downstream MAC accumulator.
REQ-011 dot_done  output  1  one-cycle pulse after the last pair of a dot product is driven.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 error  output  1  one-cycle pulse flagging a rejected command.

Function
REQ-014 The block SHALL push {in_a,in_b} into the FIFO on every cycle with in_valid && in_ready, in any state.
REQ-015 in_ready SHALL depend only on FIFO occupancy (no combinational path from pop); a full FIFO SHALL deassert in_ready even in a cycle that pops.
REQ-016 States SHALL be IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: start with vec_len != 0 SHALL latch vec_len, zero the pair counter, go to CLEAR; start with vec_len == 0 SHALL pulse error and remain IDLE.
REQ-018 CLEAR (one cycle): mac_clear=1, input1=input2=0, then go to RUN.
REQ-019 RUN: if FIFO non-empty, pop one pair, register it onto input1/input2 next edge, increment counter; if empty, drive input1=input2=0 (bubble) and do not increment.
REQ-020 RUN -> DONE on the edge at which the counter reaches the latched vec_len; no pop occurs in DONE.
REQ-021 DONE (one cycle): dot_done=1, input1=input2=0, then go to IDLE.
REQ-022 A popped pair SHALL appear on input1/input2 exactly one cycle after the pop cycle; a pair pushed at edge t into an empty FIFO in RUN SHALL be popped at edge t+1 at the earliest.
REQ-023 Negative zero (8'h80) SHALL be output as 8'h00 on input1/input2; all other codes pass unchanged.
REQ-024 start while busy SHALL be ignored and pulse error for one cycle; the running dot product SHALL continue unaffected.
REQ-025 Outside RUN, input1 and input2 SHALL be 8'h00.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-027 Pairs remaining in the FIFO after DONE SHALL be retained for the next dot product.

Reset
REQ-028 With reset high at a clock edge: state IDLE, FIFO empty, counter 0, input1=input2=8'h00, mac_clear=0, dot_done=0, busy=0, error=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard FIFO contents and abort the dot product with no dot_done pulse; reset SHALL dominate start and in_valid in the same cycle.

Verification
REQ-030 Preload pair (8'h0D,8'h0F), start vec_len=1 -> mac_clear pulse one cycle, then input1=8'h0D/input2=8'h0F one cycle, then dot_done pulse, busy low.
REQ-031 Preload (8'h0D,8'h0F),(8'h29,8'h2F),(8'h89,8'h09), start vec_len=3 -> three consecutive operand cycles in order, dot_done on the following cycle; MAC total 195+1927-81=2041.
REQ-032 Start vec_len=2 with empty FIFO, push one pair 3 cycles later and another 2 cycles after -> zero bubbles while empty, each pair output one cycle after its pop, dot_done only after second pair.
REQ-033 Push 5 pairs back-to-back into idle feeder (FIFO_DEPTH=4) -> in_ready low after the 4th push, 5th pair held upstream, no data lost or reordered.
REQ-034 start with vec_len=0, and start during RUN -> each gives a single-cycle error pulse; running count and outputs unaffected.
REQ-035 Assert reset mid-RUN with 2 pairs queued, and input 8'h80 in a later run -> all outputs at reset values, no dot_done, FIFO empty; 8'h80 emitted as 8'h00.
